// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and helpers for the perceptron predictor
package perceptron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_RESP,
    ST_UPDATE
  } state_t;

  // Accumulator width: weight width plus growth for N_IN weights and a bias.
  function automatic int sum_width(int n_in, int w_width);
    return w_width + $clog2(n_in + 1);
  endfunction

  // Weight plus or minus the learning step, clamped symmetrically to +/-wmax.
  function automatic int sat_step(int w, int lr, logic up, int wmax);
    int r;
    r = up ? (w + lr) : (w - lr);
    if (r > wmax) r = wmax;
    else if (r < -wmax) r = -wmax;
    return r;
  endfunction

endpackage

// File: rtl/perceptron_learner_if.sv
// rtl/perceptron_learner_if.sv - feature, prediction and training handshakes
interface perceptron_learner_if
  import perceptron_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int W_WIDTH = 8
);
  localparam int SUM_WIDTH = sum_width(N_IN, W_WIDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      x;
  logic                 pred_valid;
  logic                 pred_ready;
  logic                 pred;
  logic [SUM_WIDTH-1:0] pred_sum;
  logic                 train_valid;
  logic                 train_ready;
  logic                 outcome;
  logic                 learn_en;
  logic [15:0]          mispredicts;

  modport slave (
    input  in_valid, x, pred_ready, train_valid, outcome, learn_en,
    output in_ready, pred_valid, pred, pred_sum, train_ready, mispredicts
  );

  modport master (
    output in_valid, x, pred_ready, train_valid, outcome, learn_en,
    input  in_ready, pred_valid, pred, pred_sum, train_ready, mispredicts
  );

endinterface

// File: rtl/perceptron_weight_file.sv
// rtl/perceptron_weight_file.sv - weights plus bias with saturating in-place update
module perceptron_weight_file
  import perceptron_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int W_WIDTH = 8,
  parameter int LR      = 4,
  parameter int IDX_W   = $clog2(N_IN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic signed [W_WIDTH-1:0] rd_data,
  input  logic                      upd_en,
  input  logic [IDX_W-1:0]          upd_idx,
  input  logic                      upd_up
);
  localparam int WMAX = 2 ** (W_WIDTH - 1) - 1;

  // Entry N_IN is the bias.
  logic signed [W_WIDTH-1:0] mem [N_IN+1];

  // Combinational read; indices beyond the bias read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_idx <= IDX_W'(N_IN)) rd_data = mem[rd_idx];
  end

  // One saturating update per cycle; reset clears every weight and the bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N_IN; i++) mem[i] <= '0;
    end else if (upd_en && upd_idx <= IDX_W'(N_IN)) begin
      mem[upd_idx] <= W_WIDTH'(sat_step(int'(mem[upd_idx]), LR, upd_up, WMAX));
    end
  end

endmodule

// File: rtl/perceptron_learner.sv
// rtl/perceptron_learner.sv - serial online-training perceptron predictor
module perceptron_learner
  import perceptron_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int W_WIDTH = 8,
  parameter int LR      = 4,
  parameter int THETA   = 16
) (
  input logic clk,
  input logic rst_n,
  perceptron_learner_if.slave bus
);
  localparam int SUM_WIDTH = sum_width(N_IN, W_WIDTH);
  localparam int IDX_W     = $clog2(N_IN + 1);

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx;
  logic [N_IN-1:0]             x_q;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_nxt, rd_ext;
  logic signed [SUM_WIDTH:0]   sum_wide, sum_abs;
  logic                        pred_q, out_q, have_last;
  logic [15:0]                 mispredicts;
  logic [IDX_W-1:0]            rd_idx;
  logic signed [W_WIDTH-1:0]   rd_data;
  logic                        xbit, upd_en, need_update;
  logic                        in_ready, train_ready, pred_valid;
  logic                        do_accept, do_train;

  perceptron_weight_file #(
    .N_IN(N_IN), .W_WIDTH(W_WIDTH), .LR(LR), .IDX_W(IDX_W)
  ) u_weights (
    .clk(clk), .rst_n(rst_n),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .upd_en(upd_en), .upd_idx(idx), .upd_up(out_q)
  );

  // Feature bit for the current index, selection, accumulation and training decision.
  always_comb begin
    xbit = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == IDX_W'(i)) xbit = x_q[i];
    end
    rd_idx      = (state == ST_ACCUM) ? idx : IDX_W'(N_IN);
    rd_ext      = {{(SUM_WIDTH - W_WIDTH){rd_data[W_WIDTH-1]}}, rd_data};
    sum_nxt     = xbit ? (sum_q + rd_ext) : sum_q;
    sum_wide    = {sum_q[SUM_WIDTH-1], sum_q};
    sum_abs     = sum_wide[SUM_WIDTH] ? -sum_wide : sum_wide;
    need_update = bus.learn_en &&
                  ((pred_q != bus.outcome) || (sum_abs <= (SUM_WIDTH+1)'(THETA)));
    upd_en      = (state == ST_UPDATE) && ((idx == IDX_W'(N_IN)) || xbit);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; training takes priority over a new vector.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    train_ready = 1'b0;
    pred_valid  = 1'b0;
    do_accept   = 1'b0;
    do_train    = 1'b0;
    case (state)
      ST_IDLE: begin
        train_ready = have_last;
        do_train    = bus.train_valid && have_last;
        in_ready    = !(do_train && bus.in_valid);
        do_accept   = bus.in_valid && in_ready && !do_train;
        if (do_train) begin
          if (need_update) state_nxt = ST_UPDATE;
        end else if (do_accept) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM:  if (idx == IDX_W'(N_IN - 1)) state_nxt = ST_RESP;
      ST_RESP: begin
        pred_valid = 1'b1;
        if (bus.pred_ready) state_nxt = ST_IDLE;
      end
      ST_UPDATE: if (idx == IDX_W'(N_IN)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: vector capture, serial accumulation, outcome capture, mispredict count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      x_q         <= '0;
      sum_q       <= '0;
      pred_q      <= 1'b0;
      out_q       <= 1'b0;
      have_last   <= 1'b0;
      mispredicts <= '0;
    end else begin
      if (do_train) begin
        out_q <= bus.outcome;
        idx   <= '0;
        if (pred_q != bus.outcome && mispredicts != 16'hFFFF)
          mispredicts <= mispredicts + 16'd1;
      end else if (do_accept) begin
        x_q   <= bus.x;
        sum_q <= rd_ext;
        idx   <= '0;
      end
      if (state == ST_ACCUM) begin
        sum_q <= sum_nxt;
        idx   <= idx + IDX_W'(1);
        if (idx == IDX_W'(N_IN - 1)) pred_q <= ~sum_nxt[SUM_WIDTH-1];
      end
      if (state == ST_UPDATE) idx <= idx + IDX_W'(1);
      if (state == ST_RESP && bus.pred_ready) have_last <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.train_ready = train_ready;
  assign bus.pred_valid  = pred_valid;
  assign bus.pred        = pred_q;
  assign bus.pred_sum    = sum_q;
  assign bus.mispredicts = mispredicts;

endmodule

// File: tb/tb_perceptron_learner.sv
// tb/tb_perceptron_learner.sv - randomized self-checking bench for perceptron_learner
module tb_perceptron_learner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  perceptron_learner_if #(.N_IN(8), .W_WIDTH(8)) bus ();

  perceptron_learner #(.N_IN(8), .W_WIDTH(8), .LR(4), .THETA(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: weights 0..7, bias at 8, plus the remembered last prediction.
  int         mw[9];
  int         m_mis;
  bit         m_have;
  logic [7:0] m_x;
  int         m_sum;
  bit         m_pred;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mw[i] = 0;
    m_mis = 0; m_have = 0; m_x = '0; m_sum = 0; m_pred = 0;
  endtask

  function automatic int model_sum(input logic [7:0] v);
    int s;
    s = mw[8];
    for (int i = 0; i < 8; i++) if (v[i]) s += mw[i];
    return s;
  endfunction

  task automatic model_train(input bit o, input bit le, output bit upd);
    int a;
    if (m_pred != o && m_mis < 65535) m_mis++;
    a = (m_sum < 0) ? -m_sum : m_sum;
    upd = le && ((m_pred != o) || (a <= 16));
    if (upd) begin
      for (int i = 0; i < 9; i++) begin
        if (i == 8 || m_x[i]) begin
          mw[i] = mw[i] + (o ? 4 : -4);
          if (mw[i] > 127) mw[i] = 127;
          if (mw[i] < -127) mw[i] = -127;
        end
      end
    end
  endtask

  // Called and returns at a negedge.
  task automatic do_predict(input logic [7:0] v, input int hold);
    int lat;
    int exp_sum;
    bit exp_pred;
    bus.x = v;
    bus.in_valid = 1'b1;
    #1;
    check("in_ready_idle", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = 8'($urandom);
    lat = 0;
    while (!bus.pred_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("pred_latency", lat, 8);
    exp_sum = model_sum(v);
    exp_pred = (exp_sum >= 0);
    check("pred_sum", $signed(bus.pred_sum), exp_sum);
    check("pred", int'(bus.pred), int'(exp_pred));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_pred_valid", int'(bus.pred_valid), 1);
      check("hold_pred_sum", $signed(bus.pred_sum), exp_sum);
      check("hold_pred", int'(bus.pred), int'(exp_pred));
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.pred_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pred_ready = 1'b0;
    check("pred_valid_fall", int'(bus.pred_valid), 0);
    check("in_ready_back", int'(bus.in_ready), 1);
    m_x = v; m_sum = exp_sum; m_pred = exp_pred; m_have = 1;
  endtask

  // Called and returns at a negedge.
  task automatic do_train(input bit o, input bit le);
    bit upd;
    int n;
    bus.outcome = o;
    bus.learn_en = le;
    bus.train_valid = 1'b1;
    #1;
    check("train_ready", int'(bus.train_ready), int'(m_have));
    @(posedge clk);
    @(negedge clk);
    bus.train_valid = 1'b0;
    model_train(o, le, upd);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("update_cycles", n, upd ? 9 : 0);
    check("mispredicts", int'(bus.mispredicts), m_mis);
  endtask

  initial begin
    bit upd;
    bus.in_valid = 0; bus.x = '0; bus.pred_ready = 0;
    bus.train_valid = 0; bus.outcome = 0; bus.learn_en = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_pred_valid", int'(bus.pred_valid), 0);
    check("rst_pred", int'(bus.pred), 0);
    check("rst_pred_sum", $signed(bus.pred_sum), 0);
    check("rst_train_ready", int'(bus.train_ready), 0);
    check("rst_mispredicts", int'(bus.mispredicts), 0);

    do_predict(8'hFF, 0);
    do_train(1'b0, 1'b1);
    do_predict(8'h01, 0);
    check("w_all_minus4", model_sum(8'h01), -8);
    do_train(1'b0, 1'b0);
    do_predict(8'h01, 0);
    do_train(1'b0, 1'b1);
    do_predict(8'h01, 0);
    do_predict(8'h02, 0);

    for (int it = 0; it < 25; it++) begin
      do_predict(8'($urandom), $urandom_range(0, 2));
      do_train(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        do_train(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    bus.x = 8'hA5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(bus.in_ready), 1);
    check("arst_pred_valid", int'(bus.pred_valid), 0);
    check("arst_pred_sum", $signed(bus.pred_sum), 0);
    check("arst_train_ready", int'(bus.train_ready), 0);
    check("arst_mispredicts", int'(bus.mispredicts), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_train_ready", int'(bus.train_ready), 0);

    do_predict(8'hFF, 0);
    for (int t = 0; t < 40; t++) do_train(1'b1, 1'b1);
    do_predict(8'hFF, 5);
    check("sat_sum", model_sum(8'hFF), 1143);

    bus.x = 8'h3C;
    bus.in_valid = 1'b1;
    bus.outcome = 1'b0;
    bus.learn_en = 1'b0;
    bus.train_valid = 1'b1;
    #1;
    check("both_in_ready", int'(bus.in_ready), 0);
    check("both_train_ready", int'(bus.train_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.train_valid = 1'b0;
    model_train(1'b0, 1'b0, upd);
    check("both_mispredicts", int'(bus.mispredicts), m_mis);
    do_predict(8'h3C, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perceptron_learner.md
# perceptron_learner

Online-training, parametrised perceptron predictor for the adaptive low-power controller. It accepts an N_IN-bit feature vector over a valid/ready handshake and evaluates the prediction serially, one weight per cycle through a single adder. Afterwards it accepts the observed outcome and updates its weights in place with a saturating perceptron rule. It replaces fixed-weight combinational prediction wherever the power manager needs predictions that adapt at run time.

## Interface
Parameters:
- N_IN, 8: number of binary features.
- W_WIDTH, 8: signed weight/bias width; weights saturate at ±(2^(W_WIDTH-1)-1).
- LR, 4: unsigned training step added to or subtracted from a weight.
- THETA, 16: training margin; train even on a correct prediction if |sum| <= THETA.
- SUM_WIDTH, W_WIDTH+$clog2(N_IN+1): signed accumulator width (derived, not overridden).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  feature vector offered
- in_ready  out  1  block can accept a vector
- x  in  N_IN  feature bits, sampled on accept
- pred_valid  out  1  prediction available
- pred_ready  in  1  consumer takes prediction
- pred  out  1  1 when sum >= 0
- pred_sum  out  SUM_WIDTH  signed sum (confidence)
- train_valid  in  1  outcome offered for the last prediction
- train_ready  out  1  outcome can be accepted
- outcome  in  1  true result for the last vector
- learn_en  in  1  0: outcome accepted, weights frozen
- mispredicts  out  16  saturating count of pred != outcome

## Operation
- States: IDLE, ACCUM, RESP, UPDATE.
- IDLE: in_ready=1. train_ready=1 only if a prediction has completed since reset (have_last).
- If train_valid && train_ready && in_valid are all high, training wins and in_ready is driven 0 that cycle.
- Accept vector: latch x into x_q, sum <= sign-extended bias, idx <= 0, go to ACCUM.
- ACCUM: each cycle, if x_q[idx], sum += sign-extended w[idx]. idx increments. After idx = N_IN-1, go to RESP.
- RESP: pred_valid=1. pred and pred_sum are stable until pred_ready. On the handshake, set have_last and go to IDLE.
- Accept outcome: update is required when learn_en && (pred_q != outcome || |sum_q| <= THETA).
  - If not required, stay in IDLE.
  - If required, go to UPDATE with idx=0.
  - Regardless of learn_en, mispredicts increments on pred_q != outcome and saturates at 16'hFFFF.
- UPDATE: N_IN+1 cycles, one entry per cycle, bias last.
  - Update entry idx if x_q[idx]; always update the bias.
  - Step is +LR when outcome=1, -LR when outcome=0, clamped to ±(2^(W_WIDTH-1)-1).
  - Then go to IDLE. x_q and sum_q are retained, so a second outcome retrains the same vector.
- Arithmetic: all signed two's complement. The accumulator cannot overflow at SUM_WIDTH. |sum| is computed at SUM_WIDTH+1 bits.

## Timing
- Reset values:
  - State: IDLE.
  - in_ready=1, pred_valid=0, pred=0, pred_sum=0, train_ready=0, mispredicts=0.
  - All weights and bias 0; have_last=0; x_q=0.
- Accept edge at cycle k: pred_valid rises after edge k+N_IN, i.e. N_IN cycles of latency.
- Training: UPDATE occupies N_IN+1 cycles. in_ready=0 throughout.
- pred_valid falls the cycle after the pred_ready handshake. in_ready is back on the same edge.
- pred_ready while pred_valid=0 has no effect. train_valid while train_ready=0 is ignored (not queued).
- Reset asserted mid-ACCUM/RESP/UPDATE:
  - Immediately returns all state to reset values.
  - Partial weight updates are discarded by the full weight reset.

## Structure
- Shared package perceptron_pkg holds:
  - the state enum;
  - a function for the saturating signed add of a weight and ±LR;
  - a function for the derived SUM_WIDTH.
- Sub-module perceptron_weight_file holds:
  - N_IN+1 entries of W_WIDTH, with async reset to 0;
  - one combinational read port indexed by idx (index N_IN = bias);
  - one synchronous saturating-update port (enable, index, direction).
- Top level holds the FSM, the accumulator, x_q/sum_q/pred_q and the mispredict counter.

## Test plan
Defaults throughout (N_IN=8, W_WIDTH=8, LR=4, THETA=16).
- Reset, then x=8'hFF -> pred_valid exactly 8 cycles after accept; pred=1, pred_sum=0.
- Train outcome=0 on that vector -> mispredicts=1. UPDATE lasts 9 cycles. All weights and bias become -4. Query x=8'h01 -> pred_sum=-8, pred=0.
- Train outcome=0 again on x=8'h01 (correct, |-8|<=16) -> w0=-8, bias=-8, other weights unchanged, mispredicts stays 1. With learn_en=0 instead -> nothing changes.
- 40 trainings of outcome=1 on x=8'hFF -> all weights and bias clamp at 127. Query x=8'hFF -> pred_sum=1143, no wrap.
- Hold pred_ready=0 for 5 cycles -> pred and pred_sum stable, in_ready=0. Raise in_valid and train_valid together in IDLE -> training taken, vector waits.
- Drop rst_n mid-ACCUM -> outputs return to reset values asynchronously; train_ready=0 until the next completed prediction.
